// File: rtl/video_sync_normalizer_pkg.sv
// Shared constants and helpers for the video sync normaliser: default counter
// widths, the polarity encoding and the phase-length comparison used by polarity detection.
package video_pkg;

  localparam int COLOR_DEPTH = 6;
  localparam int HCNT_WIDTH  = 11;
  localparam int VCNT_WIDTH  = 10;
  localparam int PCNT_WIDTH  = 12;

  localparam logic POL_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    PHASE_HI_SHORTER = 2'd0,
    PHASE_EQUAL      = 2'd1,
    PHASE_LO_SHORTER = 2'd2
  } phase_cmp_e;

  function automatic phase_cmp_e compare_phases(input logic [31:0] cnt_hi,
                                                input logic [31:0] cnt_lo);
    phase_cmp_e res;
    if (cnt_hi < cnt_lo) begin
      res = PHASE_HI_SHORTER;
    end else if (cnt_hi > cnt_lo) begin
      res = PHASE_LO_SHORTER;
    end else begin
      res = PHASE_EQUAL;
    end
    return res;
  endfunction

endpackage

// File: rtl/video_sync_normalizer_if.sv
// Raw core video in, programmable window config, normalised video out.
// The master drives the raw video and config; the slave (normaliser) drives the results.
interface video_sync_normalizer_if #(
  parameter int COLOR_DEPTH = video_pkg::COLOR_DEPTH,
  parameter int HCNT_WIDTH  = video_pkg::HCNT_WIDTH,
  parameter int VCNT_WIDTH  = video_pkg::VCNT_WIDTH
);

  logic                   ce_pix;
  logic [COLOR_DEPTH-1:0] R_in;
  logic [COLOR_DEPTH-1:0] G_in;
  logic [COLOR_DEPTH-1:0] B_in;
  logic                   HSync_in;
  logic                   VSync_in;
  logic [HCNT_WIDTH-1:0]  h_bp;
  logic [HCNT_WIDTH-1:0]  h_act;
  logic [VCNT_WIDTH-1:0]  v_bp;
  logic [VCNT_WIDTH-1:0]  v_act;

  logic [COLOR_DEPTH-1:0] R;
  logic [COLOR_DEPTH-1:0] G;
  logic [COLOR_DEPTH-1:0] B;
  logic                   HSync;
  logic                   VSync;
  logic                   HBlank;
  logic                   VBlank;
  logic                   h_pol;
  logic                   v_pol;
  logic                   locked;

  modport master (
    output ce_pix, R_in, G_in, B_in, HSync_in, VSync_in,
    output h_bp, h_act, v_bp, v_act,
    input  R, G, B, HSync, VSync, HBlank, VBlank, h_pol, v_pol, locked
  );

  modport slave (
    input  ce_pix, R_in, G_in, B_in, HSync_in, VSync_in,
    input  h_bp, h_act, v_bp, v_act,
    output R, G, B, HSync, VSync, HBlank, VBlank, h_pol, v_pol, locked
  );

endinterface

// File: rtl/video_sync_normalizer_sync_polarity_detect.sv
// Measures the high and low phase lengths of a sync between rising edges and
// declares the shorter phase to be the sync pulse.
module sync_polarity_detect #(
  parameter int PCNT_WIDTH = video_pkg::PCNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic sync_in,
  output logic pol,
  output logic valid
);
  import video_pkg::*;

  localparam logic [PCNT_WIDTH-1:0] PCNT_MAX = '1;

  logic                  sync_q, sync_d;
  logic                  seen_q, seen_d;
  logic                  pol_q, pol_d;
  logic                  valid_q, valid_d;
  logic [PCNT_WIDTH-1:0] cnt_hi_q, cnt_hi_d;
  logic [PCNT_WIDTH-1:0] cnt_lo_q, cnt_lo_d;
  logic                  rise_s;
  phase_cmp_e            cmp_s;

  assign rise_s = sync_in & ~sync_q;
  assign cmp_s  = compare_phases(32'(cnt_hi_q), 32'(cnt_lo_q));

  // Next-state: phase counting, and a verdict on every rising edge once a full period is seen
  always_comb begin
    sync_d   = sync_q;
    seen_d   = seen_q;
    pol_d    = pol_q;
    valid_d  = valid_q;
    cnt_hi_d = cnt_hi_q;
    cnt_lo_d = cnt_lo_q;
    if (ce) begin
      sync_d = sync_in;
      if (rise_s) begin
        if (seen_q) begin
          valid_d = 1'b1;
          case (cmp_s)
            PHASE_HI_SHORTER: pol_d = POL_ACTIVE_HIGH;
            PHASE_LO_SHORTER: pol_d = ~POL_ACTIVE_HIGH;
            default:          pol_d = pol_q;
          endcase
        end else begin
          valid_d = valid_q;
        end
        seen_d   = 1'b1;
        cnt_hi_d = '0;
        cnt_lo_d = '0;
      end else if (sync_in) begin
        if (cnt_hi_q != PCNT_MAX) begin
          cnt_hi_d = cnt_hi_q + PCNT_WIDTH'(1'b1);
        end else begin
          cnt_hi_d = cnt_hi_q;
        end
      end else begin
        if (cnt_lo_q != PCNT_MAX) begin
          cnt_lo_d = cnt_lo_q + PCNT_WIDTH'(1'b1);
        end else begin
          cnt_lo_d = cnt_lo_q;
        end
      end
    end else begin
      sync_d = sync_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 1'b0;
      seen_q   <= 1'b0;
      pol_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_hi_q <= '0;
      cnt_lo_q <= '0;
    end else begin
      sync_q   <= sync_d;
      seen_q   <= seen_d;
      pol_q    <= pol_d;
      valid_q  <= valid_d;
      cnt_hi_q <= cnt_hi_d;
      cnt_lo_q <= cnt_lo_d;
    end
  end

  assign pol   = pol_q;
  assign valid = valid_q;

endmodule

// File: rtl/video_sync_normalizer.sv
// Normalises raw core syncs to active-low, derives blanking from programmable
// windows referenced to sync trailing edges, and zeroes RGB outside the window.
module video_sync_normalizer #(
  parameter int COLOR_DEPTH = video_pkg::COLOR_DEPTH,
  parameter int HCNT_WIDTH  = video_pkg::HCNT_WIDTH,
  parameter int VCNT_WIDTH  = video_pkg::VCNT_WIDTH,
  parameter int PCNT_WIDTH  = video_pkg::PCNT_WIDTH
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  video_sync_normalizer_if.slave  vid
);
  import video_pkg::*;

  localparam logic [HCNT_WIDTH-1:0] HCNT_MAX = '1;
  localparam logic [VCNT_WIDTH-1:0] VCNT_MAX = '1;

  logic                   h_pol_s, h_valid_s, v_pol_s, v_valid_s;
  logic                   hs_n_s, vs_n_s, hs_trail_s, vs_trail_s, line_ce_s;
  logic [HCNT_WIDTH-1:0]  hcnt_q, hcnt_d;
  logic [VCNT_WIDTH-1:0]  vcnt_q, vcnt_d;
  logic [HCNT_WIDTH:0]    h_end_s;
  logic [VCNT_WIDTH:0]    v_end_s;
  logic                   h_in_s, v_in_s;
  logic [COLOR_DEPTH-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic                   hsync_q, vsync_q, hblank_q, vblank_q, locked_q;

  // hsync_q/vsync_q hold the previous normalised sample, so they double as edge history
  assign hs_n_s     = vid.HSync_in ^ h_pol_s;
  assign vs_n_s     = vid.VSync_in ^ v_pol_s;
  assign hs_trail_s = hs_n_s & ~hsync_q;
  assign vs_trail_s = vs_n_s & ~vsync_q;
  assign line_ce_s  = vid.ce_pix & hs_trail_s;

  sync_polarity_detect #(.PCNT_WIDTH(PCNT_WIDTH)) u_hdet (
    .clk     (clk_sys),
    .reset   (reset),
    .ce      (vid.ce_pix),
    .sync_in (vid.HSync_in),
    .pol     (h_pol_s),
    .valid   (h_valid_s)
  );

  sync_polarity_detect #(.PCNT_WIDTH(PCNT_WIDTH)) u_vdet (
    .clk     (clk_sys),
    .reset   (reset),
    .ce      (line_ce_s),
    .sync_in (vid.VSync_in),
    .pol     (v_pol_s),
    .valid   (v_valid_s)
  );

  // Pixel counter: zero on the HS trailing edge, saturating otherwise
  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_trail_s) begin
      hcnt_d = '0;
    end else if (hcnt_q != HCNT_MAX) begin
      hcnt_d = hcnt_q + HCNT_WIDTH'(1'b1);
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Line counter: the VS trailing-edge clear beats a same-cycle line increment
  always_comb begin
    vcnt_d = vcnt_q;
    if (vs_trail_s) begin
      vcnt_d = '0;
    end else if (hs_trail_s && (vcnt_q != VCNT_MAX)) begin
      vcnt_d = vcnt_q + VCNT_WIDTH'(1'b1);
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // Windows are judged on the counter value belonging to the current pixel
  assign h_end_s = {1'b0, vid.h_bp} + {1'b0, vid.h_act};
  assign v_end_s = {1'b0, vid.v_bp} + {1'b0, vid.v_act};
  assign h_in_s  = (hcnt_d >= vid.h_bp) && ({1'b0, hcnt_d} < h_end_s);
  assign v_in_s  = (vcnt_d >= vid.v_bp) && ({1'b0, vcnt_d} < v_end_s);

  // Pixel data passes only inside both windows
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (h_in_s && v_in_s) begin
      r_d = vid.R_in;
      g_d = vid.G_in;
      b_d = vid.B_in;
    end else begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Counters and output registers, all advancing together on ce_pix
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      locked_q <= 1'b0;
    end else if (vid.ce_pix) begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hsync_q  <= hs_n_s;
      vsync_q  <= vs_n_s;
      hblank_q <= ~h_in_s;
      vblank_q <= ~v_in_s;
      locked_q <= h_valid_s & v_valid_s;
    end
  end

  assign vid.R      = r_q;
  assign vid.G      = g_q;
  assign vid.B      = b_q;
  assign vid.HSync  = hsync_q;
  assign vid.VSync  = vsync_q;
  assign vid.HBlank = hblank_q;
  assign vid.VBlank = vblank_q;
  assign vid.h_pol  = h_pol_s;
  assign vid.v_pol  = v_pol_s;
  assign vid.locked = locked_q;

endmodule

// File: tb/tb_video_sync_normalizer.sv
// Randomised video timing driven into the normaliser and compared every cycle
// against a frame-level reference model, plus window counts and polarity/lock checks.
module tb_video_sync_normalizer;

  localparam int CD   = 6;
  localparam int HW   = 11;
  localparam int VW   = 10;
  localparam int PW   = 12;
  localparam int HMAX = (1 << HW) - 1;
  localparam int VMAX = (1 << VW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic clk_sys = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  video_sync_normalizer_if #(.COLOR_DEPTH(CD), .HCNT_WIDTH(HW), .VCNT_WIDTH(VW)) vif ();

  video_sync_normalizer #(
    .COLOR_DEPTH(CD), .HCNT_WIDTH(HW), .VCNT_WIDTH(VW), .PCNT_WIDTH(PW)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vid     (vif)
  );

  always #5 clk_sys = ~clk_sys;

  // stimulus timing and window configuration
  int t_len, t_hsw, t_lines, t_vsw;
  bit t_hpol, t_vpol, rgb_fixed;
  int c_hbp, c_hact, c_vbp, c_vact;
  int act_cnt, good_cnt, bad_cnt;

  // reference model state
  bit m_hpol, m_vpol, m_hvalid, m_vvalid, m_hseen, m_vseen, m_hprev, m_vprev;
  int m_hhi, m_hlo, m_vhi, m_vlo, m_hcnt, m_vcnt;
  logic [CD-1:0] e_r, e_g, e_b;
  bit e_hs, e_vs, e_hb, e_vb, e_locked;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [CD-1:0] r, g, b,
                                       input logic hs, vs, hb, vb, hp, vp, lk);
    return {7'd0, r, g, b, hs, vs, hb, vb, hp, vp, lk};
  endfunction

  function automatic logic [31:0] dut_pack();
    return pack(vif.R, vif.G, vif.B, vif.HSync, vif.VSync, vif.HBlank, vif.VBlank,
                vif.h_pol, vif.v_pol, vif.locked);
  endfunction

  function automatic logic [31:0] exp_pack();
    return pack(e_r, e_g, e_b, e_hs, e_vs, e_hb, e_vb, m_hpol, m_vpol, e_locked);
  endfunction

  function automatic logic [31:0] reset_pack();
    return pack('0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_hpol = 0; m_vpol = 0; m_hvalid = 0; m_vvalid = 0;
    m_hseen = 0; m_vseen = 0; m_hprev = 0; m_vprev = 0;
    m_hhi = 0; m_hlo = 0; m_vhi = 0; m_vlo = 0; m_hcnt = 0; m_vcnt = 0;
    e_r = '0; e_g = '0; e_b = '0;
    e_hs = 1; e_vs = 1; e_hb = 1; e_vb = 1; e_locked = 0;
  endtask

  // Shorter phase between two rising edges is the sync pulse
  task automatic measure(input bit s, inout bit prev, inout bit seen, inout int hi,
                         inout int lo, inout bit pol, inout bit valid);
    if (s && !prev) begin
      if (seen) begin
        if (hi < lo) pol = 1;
        else if (hi > lo) pol = 0;
        valid = 1;
      end
      seen = 1; hi = 0; lo = 0;
    end else if (s) begin
      hi = sat(hi + 1, PMAX);
    end else begin
      lo = sat(lo + 1, PMAX);
    end
    prev = s;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [CD-1:0] r, g, b);
    bit hs_n, vs_n, hs_tr, vs_tr, lk;
    int hc, vc;
    lk    = m_hvalid && m_vvalid;
    hs_n  = hs ^ m_hpol;
    vs_n  = vs ^ m_vpol;
    hs_tr = hs_n && !e_hs;
    vs_tr = vs_n && !e_vs;
    measure(hs, m_hprev, m_hseen, m_hhi, m_hlo, m_hpol, m_hvalid);
    if (hs_tr) measure(vs, m_vprev, m_vseen, m_vhi, m_vlo, m_vpol, m_vvalid);
    hc = hs_tr ? 0 : sat(m_hcnt + 1, HMAX);
    vc = vs_tr ? 0 : (hs_tr ? sat(m_vcnt + 1, VMAX) : m_vcnt);
    e_hb = !(hc >= c_hbp && hc < c_hbp + c_hact);
    e_vb = !(vc >= c_vbp && vc < c_vbp + c_vact);
    e_r  = (e_hb || e_vb) ? '0 : r;
    e_g  = (e_hb || e_vb) ? '0 : g;
    e_b  = (e_hb || e_vb) ? '0 : b;
    e_hs = hs_n; e_vs = vs_n; e_locked = lk;
    m_hcnt = hc; m_vcnt = vc;
  endtask

  task automatic compare();
    check_eq("outs", dut_pack(), exp_pack());
  endtask

  // One negedge with ce held low so nothing advances while directed checks run
  task automatic idle();
    @(negedge clk_sys);
    compare();
    vif.ce_pix = 1'b0;
  endtask

  task automatic pixel(input bit hs, input bit vs);
    logic [CD-1:0] r, g, b;
    while ($urandom_range(0, 7) == 0) idle();
    @(negedge clk_sys);
    compare();
    if (!vif.HBlank && !vif.VBlank) begin
      act_cnt++;
      if (vif.R == 6'h3F && vif.G == 6'h3F && vif.B == 6'h3F) good_cnt++;
    end else if (vif.R != 6'd0 || vif.G != 6'd0 || vif.B != 6'd0) begin
      bad_cnt++;
    end
    r = rgb_fixed ? 6'h3F : 6'($urandom_range(0, 63));
    g = rgb_fixed ? 6'h3F : 6'($urandom_range(0, 63));
    b = rgb_fixed ? 6'h3F : 6'($urandom_range(0, 63));
    vif.ce_pix = 1'b1; vif.R_in = r; vif.G_in = g; vif.B_in = b;
    vif.HSync_in = hs; vif.VSync_in = vs;
    model_step(hs, vs, r, g, b);
  endtask

  task automatic run_pixels(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      int  l, p;
      bit  ha, va;
      l  = (i / t_len) % t_lines;
      p  = i % t_len;
      ha = (p < t_hsw);
      va = (l < t_vsw);
      pixel(t_hpol ? ha : !ha, t_vpol ? va : !va);
    end
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      act_cnt = 0; good_cnt = 0; bad_cnt = 0;
      run_pixels(0, t_len * t_lines);
    end
  endtask

  task automatic set_window(input int hbp, input int hact, input int vbp, input int vact);
    c_hbp = hbp; c_hact = hact; c_vbp = vbp; c_vact = vact;
    vif.h_bp = HW'(hbp); vif.h_act = HW'(hact);
    vif.v_bp = VW'(vbp); vif.v_act = VW'(vact);
  endtask

  task automatic random_window();
    int hbp, vbp;
    hbp = $urandom_range(2, 10);
    vbp = $urandom_range(2, 5);
    set_window(hbp, $urandom_range(8, t_len - t_hsw - hbp - 2),
               vbp, $urandom_range(4, t_lines - t_vsw - vbp - 2));
  endtask

  task automatic window_frame(input string tag);
    frames(1);
    check_eq({tag, "_act"},  act_cnt,  c_hact * c_vact);
    check_eq({tag, "_rgb"},  good_cnt, c_hact * c_vact);
    check_eq({tag, "_leak"}, bad_cnt,  0);
  endtask

  initial begin
    reset = 1'b1;
    vif.ce_pix = 1'b0; vif.R_in = '0; vif.G_in = '0; vif.B_in = '0;
    vif.HSync_in = 1'b0; vif.VSync_in = 1'b0;
    rgb_fixed = 0; act_cnt = 0; good_cnt = 0; bad_cnt = 0;
    t_len = $urandom_range(64, 96); t_hsw = $urandom_range(4, 10);
    t_lines = $urandom_range(30, 40); t_vsw = $urandom_range(2, 4);
    t_hpol = 1; t_vpol = 1;
    random_window();
    model_reset();

    repeat (3) @(negedge clk_sys);
    check_eq("reset_vals", dut_pack(), reset_pack());
    #2 reset = 1'b0;

    // active-high syncs lock to pol=1
    frames(3);
    idle();
    check_eq("hpol_high", vif.h_pol, 32'd1);
    check_eq("vpol_high", vif.v_pol, 32'd1);
    check_eq("locked_high", vif.locked, 32'd1);

    // fixed 0x3F data must appear exactly inside the window
    rgb_fixed = 1;
    random_window();
    window_frame("win_a");
    random_window();
    window_frame("win_b");
    rgb_fixed = 0;

    // active-low syncs flip both detectors back to pol=0
    t_hpol = 0; t_vpol = 0;
    frames(3);
    idle();
    check_eq("hpol_low", vif.h_pol, 32'd0);
    check_eq("vpol_low", vif.v_pol, 32'd0);
    check_eq("locked_low", vif.locked, 32'd1);

    // zero active width blanks the whole frame
    rgb_fixed = 1;
    set_window(c_hbp, 0, c_vbp, c_vact);
    window_frame("hact0");
    rgb_fixed = 0;
    random_window();

    // asynchronous reset mid-line, then relock on active-high syncs
    t_hpol = 1; t_vpol = 1;
    frames(1);
    run_pixels(0, 5 * t_len + t_len / 2);
    idle();
    #2 reset = 1'b1;
    #1 check_eq("rst_async", dut_pack(), reset_pack());
    check_eq("rst_locked", vif.locked, 32'd0);
    model_reset();
    repeat (3) @(negedge clk_sys);
    #2 reset = 1'b0;
    run_pixels(5 * t_len + t_len / 2, t_len * t_lines - (5 * t_len + t_len / 2));
    frames(3);
    idle();
    check_eq("relock", vif.locked, 32'd1);
    check_eq("relock_hpol", vif.h_pol, 32'd1);

    // 5000 pixels without HS: counters saturate, line stays blanked
    for (int i = 0; i < 5000; i++) pixel(1'b0, 1'b0);
    idle();
    check_eq("long_hblank", vif.HBlank, 32'd1);
    check_eq("long_rgb", {vif.R, vif.G, vif.B}, 32'd0);
    frames(2);
    idle();
    check_eq("long_locked", vif.locked, 32'd1);
    check_eq("long_hpol", vif.h_pol, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
